// File: rtl/err_alert_pkg.sv
// err_alert_pkg: shared types and constants for the error alert controller.
package err_alert_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ASSERT     = 2'd1,
      HOLDOFF    = 2'd2,
      FATAL_HOLD = 2'd3
   } alert_state_e;

   localparam int unsigned ALERT_CNT_W      = 16;
   localparam int unsigned DEFAULT_ALERT_PW = 4;
   localparam int unsigned DEFAULT_HOLDOFF  = 3;

endpackage

// File: rtl/err_sticky_latch.sv
// err_sticky_latch: rising-edge detect on a level vector plus sticky capture
// with per-bit clear. A set on the same bit and cycle as a clear wins.
module err_sticky_latch
   import err_alert_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] level,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] set,
   output logic [WIDTH-1:0] sticky
);

   logic [WIDTH-1:0] prev_q;

   assign set = level & ~prev_q;

   // Previous-level history and sticky bits, frozen while disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         sticky <= '0;
      end else if (enable) begin
         prev_q <= level;
         sticky <= (sticky & ~clr) | set;
      end
   end

endmodule

// File: rtl/err_alert_ctrl.sv
// err_alert_ctrl: latches error events into sticky status and drives the
// active-low ALERT_n pin as a pulse train, or held low while fatal.
// Optional: define ERR_ALERT_STATS_EN to implement the alert_count statistic.
module err_alert_ctrl
   import err_alert_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 8,
   parameter int unsigned PW_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_SRC-1:0]     src_warning,
   input  logic [NUM_SRC-1:0]     src_fail,
   input  logic [NUM_SRC-1:0]     src_fatal,
   input  logic [NUM_SRC-1:0]     irq_mask,
   input  logic [PW_WIDTH-1:0]    alert_pw,
   input  logic [PW_WIDTH-1:0]    alert_holdoff,
   input  logic                   clr_req,
   input  logic [NUM_SRC-1:0]     clr_src,
   output logic                   clr_ack,
   output logic                   alert_n,
   output logic [NUM_SRC-1:0]     sticky_warn,
   output logic [NUM_SRC-1:0]     sticky_fail,
   output logic [NUM_SRC-1:0]     sticky_fatal,
   output logic                   fatal_active,
   output logic [ALERT_CNT_W-1:0] alert_count
);

   alert_state_e          state_q, state_d;
   logic [PW_WIDTH-1:0]   cnt_q, cnt_d;
   logic [PW_WIDTH-1:0]   pw_eff;
   logic                  pending_q, pending_d;
   logic                  clr_ack_q, clr_seen_q;
   logic                  clr_accept;
   logic [NUM_SRC-1:0]    clr_applied;
   logic [NUM_SRC-1:0]    set_warn, set_fail, set_fatal;

   // A clear is taken once per clr_req assertion; clr_seen_q blocks re-acceptance
   // until the request drops.
   assign clr_accept  = enable & clr_req & ~clr_ack_q & ~clr_seen_q;
   assign clr_applied = clr_accept ? clr_src : '0;
   assign clr_ack     = clr_ack_q;

   assign pw_eff = (alert_pw == '0) ? PW_WIDTH'(1) : alert_pw;

   err_sticky_latch #(.WIDTH(NUM_SRC)) u_warn (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .level  (src_warning),
      .clr    (clr_applied),
      .set    (set_warn),
      .sticky (sticky_warn)
   );

   err_sticky_latch #(.WIDTH(NUM_SRC)) u_fail (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .level  (src_fail),
      .clr    (clr_applied),
      .set    (set_fail),
      .sticky (sticky_fail)
   );

   err_sticky_latch #(.WIDTH(NUM_SRC)) u_fatal (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .level  (src_fatal),
      .clr    (clr_applied),
      .set    (set_fatal),
      .sticky (sticky_fatal)
   );

   // Next-state, phase counter and pending-event flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|sticky_fatal) begin
               state_d = FATAL_HOLD;
            end else if (pending_q) begin
               state_d = ASSERT;
               cnt_d   = pw_eff - PW_WIDTH'(1);
            end
         end
         ASSERT: begin
            if (cnt_q == '0) begin
               if (|sticky_fatal) begin
                  state_d = FATAL_HOLD;
               end else begin
                  state_d = HOLDOFF;
                  cnt_d   = alert_holdoff;
               end
            end else begin
               cnt_d = cnt_q - PW_WIDTH'(1);
            end
         end
         HOLDOFF: begin
            if (cnt_q <= PW_WIDTH'(1)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - PW_WIDTH'(1);
            end
         end
         FATAL_HOLD: begin
            if (~|sticky_fatal) begin
               state_d = HOLDOFF;
               cnt_d   = alert_holdoff;
            end
         end
         default: state_d = IDLE;
      endcase

      // New events win over the clear that happens on entry to ASSERT.
      pending_d = (pending_q & ~((state_q == IDLE) && (state_d == ASSERT)))
                | (|(set_fail & ~irq_mask))
                | (|set_fatal);
   end

   // FSM state, counter, pending flag and clear handshake registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pending_q  <= 1'b0;
         clr_ack_q  <= 1'b0;
         clr_seen_q <= 1'b0;
      end else if (enable) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         clr_ack_q  <= clr_accept;
         clr_seen_q <= clr_req & (clr_seen_q | clr_accept);
      end
   end

   assign alert_n      = ~((state_q == ASSERT) || (state_q == FATAL_HOLD));
   assign fatal_active = (state_q == FATAL_HOLD);

`ifdef ERR_ALERT_STATS_EN
   logic [ALERT_CNT_W-1:0] alert_cnt_q;
   logic                   alert_entry;

   assign alert_entry = ((state_q == IDLE) && (state_d == ASSERT))
                      || ((state_q != FATAL_HOLD) && (state_d == FATAL_HOLD));

   // Saturating count of pulse starts and fatal-hold entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         alert_cnt_q <= '0;
      end else if (enable && alert_entry && (alert_cnt_q != '1)) begin
         alert_cnt_q <= alert_cnt_q + ALERT_CNT_W'(1);
      end
   end

   assign alert_count = alert_cnt_q;
`else
   assign alert_count = '0;
`endif

endmodule

// File: doc/err_alert_ctrl.md
# err_alert_ctrl

Downstream consumer of the error threshold monitor's per-source warning/fail/fatal flags and per-source interrupts. Latches rising-edge events into sticky per-source status, converts them into a DDR5-style active-low ALERT_n pulse train with programmable pulse width and hold-off, escalates fatal conditions to a continuously held alert, and supports host clear via a req/ack handshake. Sits between the threshold monitor and the RCD host-visible alert pin and status CSRs.

## Interface
Parameters:
- NUM_SRC, 8, number of error sources (1..32)
- PW_WIDTH, 8, width of pulse-width and hold-off config fields

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- enable  in  1  high = block operates; low = all state held
- src_warning  in  NUM_SRC  per-source warning level from monitor
- src_fail  in  NUM_SRC  per-source fail level
- src_fatal  in  NUM_SRC  per-source fatal level
- irq_mask  in  NUM_SRC  1 = source's fail events do not trigger alert (fatal never masked)
- alert_pw  in  PW_WIDTH  ALERT_n low time in cycles; 0 treated as 1
- alert_holdoff  in  PW_WIDTH  minimum ALERT_n high time between pulses; 0 allowed
- clr_req  in  1  level request to clear sticky bits
- clr_src  in  NUM_SRC  sticky bits to clear when clr_req accepted
- clr_ack  out  1  one-cycle acknowledge
- alert_n  out  1  active-low alert
- sticky_warn  out  NUM_SRC  latched warning events
- sticky_fail  out  NUM_SRC  latched fail events
- sticky_fatal  out  NUM_SRC  latched fatal events
- fatal_active  out  1  FSM in FATAL_HOLD
- alert_count  out  16  saturating count of ALERT_n assertions

## Operation
- Edge detect: prev_* registers of src_warning/fail/fatal; set_x = src_x & ~prev_x.
- Sticky update: sticky_next = (sticky & ~clr_applied) | set; set wins over clear on the same bit/cycle.
- pending flag: set by any set_fail & ~irq_mask or any set_fatal; cleared when FSM enters ASSERT. Warnings only latch sticky_warn, never alert.
- FSM states: IDLE, ASSERT, HOLDOFF, FATAL_HOLD.
  - IDLE: |sticky_fatal -> FATAL_HOLD; else pending -> ASSERT (load pw counter).
  - ASSERT: alert_n=0; counter reaches max(alert_pw,1) -> HOLDOFF (or FATAL_HOLD if |sticky_fatal).
  - HOLDOFF: alert_n=1; after alert_holdoff cycles -> IDLE. Events arriving here only set pending.
  - FATAL_HOLD: alert_n=0 continuously, fatal_active=1; when sticky_fatal==0 -> HOLDOFF.
- Clear handshake: clr_req accepted on first cycle high while clr_ack low; clr_applied=clr_src that cycle only; clr_ack=1 next cycle; further acceptance requires clr_req to fall first.
- alert_count increments on each IDLE->ASSERT and each entry into FATAL_HOLD; saturates at 16'hFFFF.

## Timing
- Reset (rst=1 at clock edge): alert_n=1, clr_ack=0, all sticky=0, fatal_active=0, alert_count=0, pending=0, prev_*=0, FSM=IDLE. Reset mid-pulse deasserts alert_n next edge.
- Latency: source rising at sample edge k -> sticky visible after k; alert_n low after edge k+1.
- Pulse: alert_n low exactly max(alert_pw,1) cycles; high at least alert_holdoff cycles before next pulse.
- Clear: accepted at edge k, sticky bits clear after k, clr_ack high for cycle after k only.
- enable=0: FSM, counters, sticky, prev_*, clr_ack all held; clr_req ignored.
- Config inputs sampled when loaded (entry to ASSERT/HOLDOFF); changes mid-phase ignored.

## Configuration
- ERR_ALERT_STATS_EN defined: alert_count implemented as described.
- Undefined: alert_count tied to 16'h0, counter logic removed; all other behaviour identical.

## Structure
- Package err_alert_pkg: state enum alert_state_e {IDLE, ASSERT, HOLDOFF, FATAL_HOLD}, ALERT_CNT_W=16, default pulse/hold-off constants.
- Sub-module err_sticky_latch: per-level edge detect + sticky set/clear, instantiated three times (warn, fail, fatal).

## Test plan
- Reset: drive rst 2 cycles mid-ASSERT -> alert_n=1, all sticky 0, alert_count 0 next cycle.
- src_fail[2] rises, alert_pw=4, holdoff=3 -> sticky_fail=8'h04, alert_n low 4 cycles starting 2 edges after sample, alert_count=1.
- Masked source: irq_mask[5]=1, src_fail[5] rises -> sticky_fail[5]=1, alert_n stays 1; src_warning[0] rises -> sticky_warn only, no alert.
- Back-to-back: fail[1] during ASSERT, fail[3] during HOLDOFF -> exactly one further pulse after holdoff, alert_count=2.
- Fatal: src_fatal[7] rises -> alert_n held low indefinitely; clr_req with clr_src=8'h80 -> clr_ack 1 cycle, alert_n high after clear, holdoff honoured.
- Set/clear collision: src_fail[0] rising edge same cycle clear accepted for bit 0 -> sticky_fail[0] remains 1; alert_pw=0 -> 1-cycle pulse.
